// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared control-bus indices, widths and FSM state type for pipe_ctrl.
// Revision : 1.0
// ============================================================================
package pipe_ctrl_pkg;

    localparam int XLEN      = 32;
    localparam int CTRLBUS_W = 6;

    localparam int CTRLBUS_PC     = 0;
    localparam int CTRLBUS_IF_ID  = 1;
    localparam int CTRLBUS_ID_EX  = 2;
    localparam int CTRLBUS_EX_MEM = 3;
    localparam int CTRLBUS_MEM_WB = 4;
    localparam int CTRLBUS_WB     = 5;

    localparam logic [CTRLBUS_W-1:0] C_FLUSH_TRAP   = 6'b011110;
    localparam logic [CTRLBUS_W-1:0] C_FLUSH_BRANCH = 6'b000110;
    localparam logic [CTRLBUS_W-1:0] C_FLUSH_ALL    = 6'b111111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } pipe_state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_if
// Brief    : Request/response bundle between the pipeline stages and pipe_ctrl.
// Revision : 1.0
// ============================================================================
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic                 if_stall_req_i;
    logic                 id_stall_req_i;
    logic                 ex_stall_req_i;
    logic                 mem_stall_req_i;
    logic                 branch_req_i;
    logic [XLEN-1:0]      branch_pc_i;
    logic                 trap_req_i;
    logic [XLEN-1:0]      trap_pc_i;
    logic [CTRLBUS_W-1:0] stall_valid_o;
    logic [CTRLBUS_W-1:0] flush_valid_o;
    logic                 redirect_valid_o;
    logic [XLEN-1:0]      redirect_pc_o;
    logic                 stall_timeout_o;

    modport master (
        output if_stall_req_i, id_stall_req_i, ex_stall_req_i, mem_stall_req_i,
        output branch_req_i, branch_pc_i, trap_req_i, trap_pc_i,
        input  stall_valid_o, flush_valid_o, redirect_valid_o, redirect_pc_o,
        input  stall_timeout_o
    );

    modport slave (
        input  if_stall_req_i, id_stall_req_i, ex_stall_req_i, mem_stall_req_i,
        input  branch_req_i, branch_pc_i, trap_req_i, trap_pc_i,
        output stall_valid_o, flush_valid_o, redirect_valid_o, redirect_pc_o,
        output stall_timeout_o
    );

endinterface
`default_nettype wire

// File: rtl/pipe_stall_timer.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_timer
// Brief    : Saturating consecutive-stall counter with a sticky timeout flag.
// Revision : 1.0
// ============================================================================
module pipe_stall_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_stall,
    output logic      o_timeout
);

    localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  C_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_timeout;

    always_comb begin
        w_cnt_next = '0;
        if (i_stall) begin
            w_cnt_next = (r_cnt == C_LIMIT) ? r_cnt : r_cnt + 1'b1;
        end
    end

    // Flag rises on the same edge the count reaches the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_timeout <= r_timeout | (w_cnt_next == C_LIMIT);
        end
    end

    assign o_timeout = r_timeout;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Brief    : Pipeline stall/flush/redirect controller with pending-redirect FSM.
// Revision : 1.0
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire logic   clk,
    input  wire logic   rst,
    pipe_ctrl_if.slave  bus
);

    pipe_state_e          r_state;
    pipe_state_e          w_state_next;
    logic [XLEN-1:0]      r_pend_pc;
    logic [XLEN-1:0]      w_pend_pc_next;

    logic                 w_any_stall;
    logic                 w_trap_acc;
    logic                 w_branch_acc;
    logic                 w_redir_acc;
    logic [XLEN-1:0]      w_target;
    logic [CTRLBUS_W-1:0] w_stall_raw;
    logic [CTRLBUS_W-1:0] w_flush_stall;
    logic [CTRLBUS_W-1:0] w_flush_redir;
    logic [CTRLBUS_W-1:0] w_flush;
    logic [CTRLBUS_W-1:0] w_stall;
    logic                 w_force_if_flush;
    logic                 w_redir_valid;
    logic [XLEN-1:0]      w_redir_pc;
    logic                 w_timeout;

    assign w_any_stall  = bus.if_stall_req_i | bus.id_stall_req_i |
                          bus.ex_stall_req_i | bus.mem_stall_req_i;
    assign w_trap_acc   = bus.trap_req_i & ~bus.mem_stall_req_i;
    assign w_branch_acc = bus.branch_req_i & ~bus.ex_stall_req_i & ~bus.mem_stall_req_i;
    assign w_redir_acc  = w_trap_acc | w_branch_acc;
    assign w_target     = w_trap_acc ? bus.trap_pc_i : bus.branch_pc_i;

    // Hold everything up to the highest stalled stage, bubble the one behind it.
    always_comb begin
        w_stall_raw   = '0;
        w_flush_stall = '0;
        if (bus.mem_stall_req_i) begin
            w_stall_raw   = 6'b001111;
            w_flush_stall = 6'b010000;
        end else if (bus.ex_stall_req_i) begin
            w_stall_raw   = 6'b000111;
            w_flush_stall = 6'b001000;
        end else if (bus.id_stall_req_i) begin
            w_stall_raw   = 6'b000011;
            w_flush_stall = 6'b000100;
        end else if (bus.if_stall_req_i) begin
            w_stall_raw   = 6'b000001;
            w_flush_stall = 6'b000010;
        end
    end

    always_comb begin
        w_flush_redir = '0;
        if (w_trap_acc) begin
            w_flush_redir = C_FLUSH_TRAP;
        end else if (w_branch_acc) begin
            w_flush_redir = C_FLUSH_BRANCH;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_pend_pc_next   = r_pend_pc;
        w_redir_valid    = 1'b0;
        w_redir_pc       = '0;
        w_force_if_flush = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_redir_acc) begin
                    if (bus.if_stall_req_i) begin
                        w_state_next   = ST_PEND;
                        w_pend_pc_next = w_target;
                    end else begin
                        w_redir_valid  = 1'b1;
                        w_redir_pc     = w_target;
                    end
                end
            end
            ST_PEND: begin
                // Whatever fetch returns while pending is wrong-path.
                w_force_if_flush = 1'b1;
                if (bus.if_stall_req_i) begin
                    if (w_redir_acc) begin
                        w_pend_pc_next = w_target;
                    end
                end else begin
                    w_redir_valid = 1'b1;
                    w_redir_pc    = w_redir_acc ? w_target : r_pend_pc;
                    w_state_next  = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_flush = w_flush_stall | w_flush_redir;
        w_flush[CTRLBUS_IF_ID] = w_flush[CTRLBUS_IF_ID] | w_force_if_flush;
        w_stall = w_stall_raw & ~w_flush;
        if (w_redir_valid) begin
            w_stall[CTRLBUS_PC] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pend_pc <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pend_pc <= w_pend_pc_next;
        end
    end

    pipe_stall_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clk       (clk),
        .rst       (rst),
        .i_stall   (w_any_stall),
        .o_timeout (w_timeout)
    );

    assign bus.stall_valid_o    = rst ? '0          : w_stall;
    assign bus.flush_valid_o    = rst ? C_FLUSH_ALL : w_flush;
    assign bus.redirect_valid_o = rst ? 1'b0        : w_redir_valid;
    assign bus.redirect_pc_o    = rst ? '0          : w_redir_pc;
    assign bus.stall_timeout_o  = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Brief    : Directed and randomized self-checking bench for pipe_ctrl.
// Revision : 1.0
// ============================================================================
module tb_pipe_ctrl;

    localparam int T_CYC = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    // Reference model state
    bit          m_pend;
    logic [31:0] m_pend_pc;
    int          m_cnt;
    bit          m_to;

    pipe_ctrl_if u_if();

    pipe_ctrl #(.TIMEOUT_CYCLES(T_CYC)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input bit ifs, input bit ids, input bit exs, input bit mems,
                         input bit br, input logic [31:0] bpc,
                         input bit tr, input logic [31:0] tpc);
        u_if.if_stall_req_i  = ifs;
        u_if.id_stall_req_i  = ids;
        u_if.ex_stall_req_i  = exs;
        u_if.mem_stall_req_i = mems;
        u_if.branch_req_i    = br;
        u_if.branch_pc_i     = bpc;
        u_if.trap_req_i      = tr;
        u_if.trap_pc_i       = tpc;
    endtask

    task automatic model_reset();
        m_pend = 0; m_pend_pc = '0; m_cnt = 0; m_to = 0;
    endtask

    // Expected combinational outputs from the current inputs and model state.
    task automatic model_expect(output logic [5:0] es, output logic [5:0] ef,
                                output logic erv, output logic [31:0] epc);
        int s;
        bit tacc, bacc;
        logic [31:0] tgt;
        s = u_if.mem_stall_req_i ? 3 : u_if.ex_stall_req_i ? 2 :
            u_if.id_stall_req_i ? 1 : u_if.if_stall_req_i ? 0 : -1;
        es = (s >= 0) ? 6'((1 << (s + 1)) - 1) : 6'd0;
        ef = (s >= 0) ? 6'(1 << (s + 1)) : 6'd0;
        tacc = u_if.trap_req_i && !u_if.mem_stall_req_i;
        bacc = u_if.branch_req_i && !u_if.ex_stall_req_i && !u_if.mem_stall_req_i;
        tgt  = tacc ? u_if.trap_pc_i : u_if.branch_pc_i;
        if (tacc)      ef = ef | 6'h1E;
        else if (bacc) ef = ef | 6'h06;
        if (m_pend)    ef = ef | 6'h02;
        erv = m_pend ? !u_if.if_stall_req_i : ((tacc || bacc) && !u_if.if_stall_req_i);
        epc = !erv ? 32'd0 : ((tacc || bacc) ? tgt : m_pend_pc);
        es = es & ~ef;
        if (erv) es[0] = 1'b0;
    endtask

    task automatic model_edge();
        bit acc;
        logic [31:0] tgt;
        bit anys;
        if (rst) begin
            model_reset();
            return;
        end
        acc = (u_if.trap_req_i && !u_if.mem_stall_req_i) ||
              (u_if.branch_req_i && !u_if.ex_stall_req_i && !u_if.mem_stall_req_i);
        tgt = (u_if.trap_req_i && !u_if.mem_stall_req_i) ? u_if.trap_pc_i : u_if.branch_pc_i;
        anys = u_if.if_stall_req_i || u_if.id_stall_req_i ||
               u_if.ex_stall_req_i || u_if.mem_stall_req_i;
        if (anys) begin
            m_cnt = (m_cnt + 1 > T_CYC) ? T_CYC : m_cnt + 1;
            if (m_cnt == T_CYC) m_to = 1;
        end else begin
            m_cnt = 0;
        end
        if (m_pend) begin
            if (!u_if.if_stall_req_i) m_pend = 0;
            else if (acc)             m_pend_pc = tgt;
        end else if (acc && u_if.if_stall_req_i) begin
            m_pend = 1;
            m_pend_pc = tgt;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 0, 1, 0, 1, 32'h1234_5678, 1, 32'h8765_4320);
        model_reset();
        @(negedge clk);
        n_checks++;
        if ({u_if.stall_valid_o, u_if.flush_valid_o, u_if.redirect_valid_o,
             u_if.redirect_pc_o, u_if.stall_timeout_o} !== {6'h00, 6'h3F, 1'b0, 32'h0, 1'b0})
            begin n_fail++; $display("FAIL reset: stall=%b flush=%b rv=%b pc=%h to=%b want 000000/111111/0/0/0",
                u_if.stall_valid_o, u_if.flush_valid_o, u_if.redirect_valid_o,
                u_if.redirect_pc_o, u_if.stall_timeout_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
    endtask

    task automatic test_stall_priority();
        logic [3:0] pat [5]  = '{4'b1010, 4'b0100, 4'b0001, 4'b0000, 4'b0011};
        logic [5:0] xs  [5]  = '{6'b001111, 6'b000111, 6'b000001, 6'b000000, 6'b000011};
        logic [5:0] xf  [5]  = '{6'b010000, 6'b001000, 6'b000010, 6'b000000, 6'b000100};
        for (int i = 0; i < 5; i++) begin
            drive(pat[i][0], pat[i][1], pat[i][2], pat[i][3], 0, 0, 0, 0);
            @(negedge clk);
            n_checks++;
            if ({u_if.stall_valid_o, u_if.flush_valid_o, u_if.redirect_valid_o} !== {xs[i], xf[i], 1'b0})
                begin n_fail++; $display("FAIL stall_prio[%0d]: stall=%b flush=%b rv=%b want %b/%b/0",
                    i, u_if.stall_valid_o, u_if.flush_valid_o, u_if.redirect_valid_o, xs[i], xf[i]); end
            tick();
        end
    endtask

    task automatic test_branch_idle();
        drive(0, 1, 0, 0, 1, 32'h8000_0100, 0, 0);
        @(negedge clk);
        n_checks++;
        if ({u_if.stall_valid_o, u_if.flush_valid_o, u_if.redirect_valid_o, u_if.redirect_pc_o}
            !== {6'b000000, 6'b000110, 1'b1, 32'h8000_0100})
            begin n_fail++; $display("FAIL branch_idle: stall=%b flush=%b rv=%b pc=%h want 000000/000110/1/80000100",
                u_if.stall_valid_o, u_if.flush_valid_o, u_if.redirect_valid_o, u_if.redirect_pc_o); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_branch_pend();
        drive(1, 0, 0, 0, 1, 32'h8000_0200, 0, 0);
        @(negedge clk);
        n_checks++;
        if ({u_if.stall_valid_o, u_if.flush_valid_o, u_if.redirect_valid_o} !== {6'b000001, 6'b000110, 1'b0})
            begin n_fail++; $display("FAIL pend_entry: stall=%b flush=%b rv=%b want 000001/000110/0",
                u_if.stall_valid_o, u_if.flush_valid_o, u_if.redirect_valid_o); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            n_checks++;
            if ({u_if.stall_valid_o, u_if.flush_valid_o, u_if.redirect_valid_o} !== {6'b000001, 6'b000010, 1'b0})
                begin n_fail++; $display("FAIL pend_hold[%0d]: stall=%b flush=%b rv=%b want 000001/000010/0",
                    i, u_if.stall_valid_o, u_if.flush_valid_o, u_if.redirect_valid_o); end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if ({u_if.stall_valid_o, u_if.flush_valid_o, u_if.redirect_valid_o, u_if.redirect_pc_o}
            !== {6'b000000, 6'b000010, 1'b1, 32'h8000_0200})
            begin n_fail++; $display("FAIL pend_release: stall=%b flush=%b rv=%b pc=%h want 000000/000010/1/80000200",
                u_if.stall_valid_o, u_if.flush_valid_o, u_if.redirect_valid_o, u_if.redirect_pc_o); end
        tick();
        @(negedge clk);
        n_checks++;
        if (u_if.redirect_valid_o !== 1'b0 || u_if.flush_valid_o !== 6'b0)
            begin n_fail++; $display("FAIL pend_back_idle: rv=%b flush=%b want 0/000000",
                u_if.redirect_valid_o, u_if.flush_valid_o); end
        tick();
    endtask

    task automatic test_trap_overwrite();
        drive(1, 0, 0, 0, 1, 32'h8000_0200, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 1, 32'h8000_0004);
        @(negedge clk);
        n_checks++;
        if (u_if.redirect_valid_o !== 1'b0)
            begin n_fail++; $display("FAIL trap_in_pend: rv=%b want 0", u_if.redirect_valid_o); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if ({u_if.redirect_valid_o, u_if.redirect_pc_o} !== {1'b1, 32'h8000_0004})
            begin n_fail++; $display("FAIL trap_overwrite: rv=%b pc=%h want 1/80000004",
                u_if.redirect_valid_o, u_if.redirect_pc_o); end
        tick();
        drive(0, 0, 0, 0, 1, 32'h8000_0300, 1, 32'h8000_0008);
        @(negedge clk);
        n_checks++;
        if ({u_if.stall_valid_o, u_if.flush_valid_o, u_if.redirect_valid_o, u_if.redirect_pc_o}
            !== {6'b000000, 6'b011110, 1'b1, 32'h8000_0008})
            begin n_fail++; $display("FAIL trap_vs_branch: stall=%b flush=%b rv=%b pc=%h want 000000/011110/1/80000008",
                u_if.stall_valid_o, u_if.flush_valid_o, u_if.redirect_valid_o, u_if.redirect_pc_o); end
        tick();
    endtask

    task automatic test_trap_blocked();
        drive(0, 0, 0, 1, 0, 0, 1, 32'h8000_0040);
        @(negedge clk);
        n_checks++;
        if ({u_if.stall_valid_o, u_if.flush_valid_o, u_if.redirect_valid_o} !== {6'b001111, 6'b010000, 1'b0})
            begin n_fail++; $display("FAIL trap_blocked: stall=%b flush=%b rv=%b want 001111/010000/0",
                u_if.stall_valid_o, u_if.flush_valid_o, u_if.redirect_valid_o); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 32'h8000_0040);
        @(negedge clk);
        n_checks++;
        if ({u_if.flush_valid_o, u_if.redirect_valid_o, u_if.redirect_pc_o} !== {6'b011110, 1'b1, 32'h8000_0040})
            begin n_fail++; $display("FAIL trap_after_mem: flush=%b rv=%b pc=%h want 011110/1/80000040",
                u_if.flush_valid_o, u_if.redirect_valid_o, u_if.redirect_pc_o); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_watchdog();
        rst = 1'b1; #1; rst = 1'b0;
        model_reset();
        for (int i = 0; i < T_CYC; i++) begin
            drive(0, 0, 1, 0, 0, 0, 0, 0);
            @(negedge clk);
            n_checks++;
            if (u_if.stall_timeout_o !== 1'b0)
                begin n_fail++; $display("FAIL wdog_early[%0d]: to=%b want 0", i, u_if.stall_timeout_o); end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            n_checks++;
            if (u_if.stall_timeout_o !== 1'b1)
                begin n_fail++; $display("FAIL wdog_sticky[%0d]: to=%b want 1", i, u_if.stall_timeout_o); end
            tick();
        end
    endtask

    task automatic test_reset_mid_pend();
        drive(1, 0, 0, 0, 1, 32'h8000_0500, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({u_if.stall_valid_o, u_if.flush_valid_o, u_if.redirect_valid_o,
             u_if.redirect_pc_o, u_if.stall_timeout_o} !== {6'h00, 6'h3F, 1'b0, 32'h0, 1'b0})
            begin n_fail++; $display("FAIL reset_mid_pend: stall=%b flush=%b rv=%b pc=%h to=%b want 000000/111111/0/0/0",
                u_if.stall_valid_o, u_if.flush_valid_o, u_if.redirect_valid_o,
                u_if.redirect_pc_o, u_if.stall_timeout_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if ({u_if.flush_valid_o, u_if.redirect_valid_o} !== {6'b000000, 1'b0})
            begin n_fail++; $display("FAIL pend_discarded: flush=%b rv=%b want 000000/0",
                u_if.flush_valid_o, u_if.redirect_valid_o); end
        tick();
    endtask

    task automatic test_random();
        logic [5:0]  es, ef;
        logic        erv;
        logic [31:0] epc;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(3) == 0, $urandom_range(5) == 0, $urandom_range(5) == 0,
                  $urandom_range(4) == 0, $urandom_range(2) == 0, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(4) == 0, $urandom & 32'hFFFF_FFFC);
            @(negedge clk);
            model_expect(es, ef, erv, epc);
            n_checks++;
            if ({u_if.stall_valid_o, u_if.flush_valid_o, u_if.redirect_valid_o,
                 u_if.redirect_pc_o, u_if.stall_timeout_o} !== {es, ef, erv, epc, m_to})
                begin n_fail++; $display("FAIL random[%0d]: stall=%b flush=%b rv=%b pc=%h to=%b want %b/%b/%b/%h/%b",
                    i, u_if.stall_valid_o, u_if.flush_valid_o, u_if.redirect_valid_o,
                    u_if.redirect_pc_o, u_if.stall_timeout_o, es, ef, erv, epc, m_to); end
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_stall_priority();
        test_branch_idle();
        test_branch_pend();
        test_trap_overwrite();
        test_trap_blocked();
        test_watchdog();
        test_reset_mid_pend();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
